uart_tx_sched: RTL and testbench

//   Shares the single UART transmitter between NUM_CH byte-stream requesters (camera init log,

---
 rtl/uart_tx_sched.sv | 109 ++++++++++
 tb/tb_uart_tx_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin, packet-locked arbiter sharing one UART_TX among NUM_CH byte streams.
// tx_finish arrives from the clk_uart domain and is synchronised before use.
module uart_tx_sched #(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [NUM_CH-1:0]     req_last,
  input  logic [8*NUM_CH-1:0]   req_data,
  output logic [NUM_CH-1:0]     req_ready,
  output logic [NUM_CH-1:0]     grant,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_finish,
  output logic                  busy,
  output logic                  ack_timeout
);
  localparam int OW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int TW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} state_t;
  state_t               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d, last_owner_q, last_owner_d, pick, idx;
  logic [7:0]           data_q, data_d;
  logic                 last_q, last_d, ack_q, ack_d, found, fin_s;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [SYNC_STAGES-1:0] sync_q;
  assign fin_s       = sync_q[SYNC_STAGES-1];
  assign busy        = state_q != IDLE;
  assign tx_start    = state_q == START;
  assign tx_data     = data_q;
  assign ack_timeout = ack_q;
  assign grant       = busy ? NUM_CH'(1) << owner_q : '0;
  assign req_ready   = (state_q == LOAD && fin_s && req_valid[owner_q]) ? grant : '0;
  // Search starts one past the previous owner and wraps, giving strict rotation.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = last_owner_q;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (idx == OW'(NUM_CH - 1)) ? '0 : idx + 1'b1;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    data_d       = data_q;
    last_d       = last_q;
    tmo_d        = tmo_q;
    ack_d        = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        owner_d = pick;
        state_d = LOAD;
      end
      LOAD: if (fin_s && req_valid[owner_q]) begin
        data_d  = req_data[{owner_q, 3'b000} +: 8];
        last_d  = req_last[owner_q];
        tmo_d   = '0;
        state_d = START;
      end
      START: if (!fin_s) begin
        tmo_d   = '0;
        state_d = WAIT_DONE;
      end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
        ack_d        = 1'b1;
        tmo_d        = '0;
        last_owner_d = owner_q;
        state_d      = IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      WAIT_DONE: if (fin_s) begin
        state_d      = last_q ? IDLE : LOAD;
        last_owner_d = last_q ? owner_q : last_owner_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_CH - 1);
      data_q       <= '0;
      last_q       <= 1'b0;
      tmo_q        <= '0;
      ack_q        <= 1'b0;
      sync_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      data_q       <= data_d;
      last_q       <= last_d;
      tmo_q        <= tmo_d;
      ack_q        <= ack_d;
      sync_q[0]    <= tx_finish;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench; per-channel byte sources, a UART_TX model and a monitor
// that checks every byte handed to the UART against the expected owner/data sequence.
module tb_uart_tx_sched;
  localparam int NUM_CH = 3;
  localparam int SYNC_STAGES = 2;
  localparam int ACK_TIMEOUT = 1024;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_CH-1:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [8*NUM_CH-1:0] req_data = '0;
  logic tx_start, tx_finish, busy, ack_timeout;
  logic [7:0] tx_data;
  logic model_en = 1'b1, m_fin = 1'b1, man_fin = 1'b1;
  logic [8:0] src [NUM_CH][$];
  logic [10:0] exp_q [$];
  logic [NUM_CH-1:0] pend = '0;
  int vec = 0, err = 0, cyc = 0, ack_cnt = 0, rdy_cnt = 0;
  assign tx_finish = model_en ? m_fin : man_fin;
  uart_tx_sched #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_finish(tx_finish), .busy(busy), .ack_timeout(ack_timeout));
  always #5 sys_clk = ~sys_clk;
  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic send(int c, logic last, logic [7:0] d);
    src[c].push_back({last, d});
  endtask
  task automatic expect_b(logic [2:0] g, logic [7:0] d);
    exp_q.push_back({g, d});
  endtask
  // Sources: ready seen before a posedge means that edge accepted the head byte.
  initial forever begin
    @(negedge sys_clk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (pend[c] && src[c].size() > 0) void'(src[c].pop_front());
      req_valid[c] = src[c].size() > 0;
      req_last[c]  = 1'b0;
      req_data[8*c +: 8] = 8'h00;
      if (src[c].size() > 0) begin
        req_last[c] = src[c][0][8];
        req_data[8*c +: 8] = src[c][0][7:0];
      end
    end
    #1;
    pend = req_ready;
  end
  // UART_TX model: goes busy a few cycles after tx_start, stays busy for a short frame.
  initial forever begin
    @(negedge sys_clk);
    if (model_en && tx_start && m_fin) begin
      repeat (3) @(negedge sys_clk);
      m_fin = 1'b0;
      repeat (12) @(negedge sys_clk);
      m_fin = 1'b1;
    end
  end
  // Monitor: every rising tx_start must present the next expected owner and byte.
  initial begin
    logic prev_start = 1'b0;
    logic [10:0] e;
    forever begin
      @(negedge sys_clk);
      #2;
      if (tx_start && !prev_start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {21'd0, grant, tx_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("byte_owner_data", {21'd0, grant, tx_data}, {21'd0, e});
        end
      end
      prev_start = tx_start;
      if (req_ready != '0) begin
        rdy_cnt++;
        chk("ready_onehot_owner", {29'd0, req_ready}, {29'd0, grant});
      end
      if (ack_timeout) ack_cnt++;
    end
  end
  task automatic wait_idle(string nm, int lim);
    int n;
    for (n = 0; n < lim; n++) begin
      @(negedge sys_clk);
      #2;
      if (!busy && exp_q.size() == 0 && src[0].size() == 0 && src[1].size() == 0 &&
          src[2].size() == 0 && tx_finish) break;
    end
    chk({nm, "_idle_timeout"}, {31'd0, n >= lim}, 32'd0);
    chk({nm, "_grant_idle"}, {29'd0, grant}, 32'd0);
  endtask
  initial begin
    int n, t0, t1, r0;
    // Reset with every channel requesting.
    send(0, 1'b1, 8'hAA); send(1, 1'b1, 8'hBB); send(2, 1'b1, 8'hCC);
    expect_b(3'b001, 8'hAA); expect_b(3'b010, 8'hBB); expect_b(3'b100, 8'hCC);
    repeat (3) @(negedge sys_clk);
    #2;
    chk("rst_grant", {29'd0, grant}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_req_ready", {29'd0, req_ready}, 32'd0);
    chk("rst_ack", {31'd0, ack_timeout}, 32'd0);
    rst = 1'b0;
    for (n = 0; n < 20 && grant == '0; n++) begin
      @(negedge sys_clk);
      #2;
    end
    chk("first_grant", {29'd0, grant}, 32'd1);
    wait_idle("t1", 400);
    // Packet lock: ch0 owns the link for 4 bytes while ch2 waits.
    send(2, 1'b1, 8'h55);
    send(0, 1'b0, 8'h01); send(0, 1'b0, 8'h02); send(0, 1'b0, 8'h03); send(0, 1'b1, 8'h04);
    expect_b(3'b001, 8'h01); expect_b(3'b001, 8'h02); expect_b(3'b001, 8'h03);
    expect_b(3'b001, 8'h04); expect_b(3'b100, 8'h55);
    wait_idle("t3", 600);
    // Single one-byte packet on ch1.
    r0 = rdy_cnt;
    send(1, 1'b1, 8'hA5);
    expect_b(3'b010, 8'hA5);
    wait_idle("t2", 200);
    chk("t2_ready_pulses", rdy_cnt - r0, 32'd1);
    // Round-robin: rotation resumes after ch1.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NUM_CH; c++) send(c, 1'b1, 8'(8'h10 * (r + 1) + c));
      expect_b(3'b100, 8'(8'h10 * (r + 1) + 2));
      expect_b(3'b001, 8'(8'h10 * (r + 1)));
      expect_b(3'b010, 8'(8'h10 * (r + 1) + 1));
    end
    wait_idle("t4", 1000);
    // Timeout: UART never goes busy.
    model_en = 1'b0;
    man_fin = 1'b1;
    send(0, 1'b1, 8'h3C); send(1, 1'b1, 8'h77);
    expect_b(3'b001, 8'h3C); expect_b(3'b010, 8'h77);
    for (n = 0; n < 50 && !tx_start; n++) begin
      @(negedge sys_clk);
      #2;
    end
    t0 = cyc;
    for (n = 0; n < ACK_TIMEOUT + 100 && !ack_timeout; n++) begin
      @(negedge sys_clk);
      #2;
    end
    t1 = cyc;
    chk("ack_latency", t1 - t0, ACK_TIMEOUT);
    model_en = 1'b1;
    wait_idle("t5", 300);
    chk("ack_count", ack_cnt, 32'd1);
    // Reset mid-byte while in WAIT_DONE.
    model_en = 1'b0;
    man_fin = 1'b1;
    send(0, 1'b1, 8'h9E);
    expect_b(3'b001, 8'h9E);
    for (n = 0; n < 50 && !tx_start; n++) begin
      @(negedge sys_clk);
      #2;
    end
    man_fin = 1'b0;
    for (n = 0; n < 20 && tx_start; n++) begin
      @(negedge sys_clk);
      #2;
    end
    chk("t6_in_wait_done", {31'd0, busy && !tx_start}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_grant", {29'd0, grant}, 32'd0);
    chk("t6_async_tx_start", {31'd0, tx_start}, 32'd0);
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    send(0, 1'b1, 8'h9F);
    expect_b(3'b001, 8'h9F);
    r0 = rdy_cnt;
    repeat (10) @(negedge sys_clk);
    #2;
    chk("t6_no_load_while_busy", rdy_cnt - r0, 32'd0);
    chk("t6_no_start_while_busy", {31'd0, tx_start}, 32'd0);
    @(negedge sys_clk);
    man_fin = 1'b1;
    for (n = 1; n < 20; n++) begin
      @(negedge sys_clk);
      #2;
      if (req_ready != '0) break;
    end
    chk("t6_load_latency", n, SYNC_STAGES);
    model_en = 1'b1;
    wait_idle("t6", 300);
    chk("final_ack_count", ack_cnt, 32'd1);
    chk("exp_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "timeout");
  end
endmodule
